// File: rtl/conv_fp_accum_ctrl.sv
// Reduces N_TAPS FP32 products into one pixel by driving a shared external
// combinational FP32 adder, then presents the pixel on a valid/ready output.
// Ports: CLK/RST (sync, active-high), flush.
// Ports: in_valid/in_ready/in_data (product beats).
// Ports: add_op_a/add_op_b/add_op/add_result (adder interface).
// Ports: out_valid/out_ready/out_data (pixel), tap_cnt, pix_cnt (status).
// Option: define CONV_ACCUM_ZERO_SKIP_EN to make beats whose exponent field
// is zero count as taps without touching the accumulator.
module conv_fp_accum_ctrl #(
  parameter int N_TAPS = 9,
  parameter int CNT_W  = 4,
  parameter int PIX_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [31:0]      add_op_a,
  output logic [31:0]      add_op_b,
  output logic             add_op,
  input  logic [31:0]      add_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] tap_cnt,
  output logic [PIX_W-1:0] pix_cnt
);

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);

  state_t           state;
  state_t           state_n;
  logic [31:0]      acc;
  logic [31:0]      acc_n;
  logic             have_acc;
  logic             have_acc_n;
  logic [CNT_W-1:0] tap_n;
  logic [PIX_W-1:0] pix_n;
  logic             skip;

`ifdef CONV_ACCUM_ZERO_SKIP_EN
  // Zero/denormal products contribute nothing; keep them off the adder.
  assign skip = (in_data[30:23] == 8'd0);
`else
  assign skip = 1'b0;
`endif

  assign add_op_a = acc;
  assign add_op_b = in_data;
  assign add_op   = 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ACC;
      acc      <= 32'h0;
      have_acc <= 1'b0;
      tap_cnt  <= '0;
      pix_cnt  <= '0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      have_acc <= have_acc_n;
      tap_cnt  <= tap_n;
      pix_cnt  <= pix_n;
    end
  end

  always_comb begin
    state_n    = state;
    acc_n      = acc;
    have_acc_n = have_acc;
    tap_n      = tap_cnt;
    pix_n      = pix_cnt;
    in_ready   = (state == ACC);
    out_valid  = (state == OUT);
    out_data   = 32'h0;
    if (state == OUT && have_acc) begin
      out_data = acc;
    end

    if (flush) begin
      state_n    = ACC;
      acc_n      = 32'h0;
      have_acc_n = 1'b0;
      tap_n      = '0;
    end else if (state == ACC) begin
      if (in_valid) begin
        tap_n = tap_cnt + 1'b1;
        if (!skip) begin
          // First operand bypasses the adder so it never sees a +0 operand.
          acc_n      = have_acc ? add_result : in_data;
          have_acc_n = 1'b1;
        end
        if (tap_cnt == LAST_TAP) begin
          tap_n   = '0;
          state_n = OUT;
        end
      end
    end else begin
      if (out_ready) begin
        state_n    = ACC;
        acc_n      = 32'h0;
        have_acc_n = 1'b0;
        pix_n      = pix_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_fp_accum_ctrl.sv
// Directed bench for conv_fp_accum_ctrl with a behavioural FP32 adder.
// Expected pixels are hand-computed IEEE-754 constants.
module tb_conv_fp_accum_ctrl;

  localparam logic [31:0] F0  = 32'h00000000;
  localparam logic [31:0] F1  = 32'h3F800000;
  localparam logic [31:0] F2  = 32'h40000000;
  localparam logic [31:0] F3  = 32'h40400000;
  localparam logic [31:0] FM1 = 32'hBF800000;
  localparam logic [31:0] F9  = 32'h41100000;
  localparam logic [31:0] F18 = 32'h41900000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] add_op_a;
  logic [31:0] add_op_b;
  logic        add_op;
  logic [31:0] add_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  tap_cnt;
  logic [15:0] pix_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_pix = 0;

  always #5 CLK = ~CLK;

  conv_fp_accum_ctrl dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_op_a(add_op_a), .add_op_b(add_op_b), .add_op(add_op),
    .add_result(add_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tap_cnt(tap_cnt), .pix_cnt(pix_cnt)
  );

  function automatic real fp2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    real         a;
    int          e;
    logic [22:0] mt;
    logic [7:0]  ex;
    if (r == 0.0) return 32'h0;
    a = (r < 0.0) ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    mt = 23'($rtoi((a - 1.0) * 8388608.0));
    ex = 8'(e + 127);
    return {(r < 0.0), ex, mt};
  endfunction

  always_comb add_result = r2fp(fp2r(add_op_a) + fp2r(add_op_b));

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic put9(input logic [31:0] d);
    for (int i = 0; i < 9; i++) put(d);
  endtask

  task automatic take(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    step();
    exp_pix++;
    chk({tag, "_pix"}, {16'b0, pix_cnt}, 32'(exp_pix));
    chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ir"}, {31'b0, in_ready}, 32'd1);
    chk({tag, "_ov"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_od"}, out_data, 32'h0);
    chk({tag, "_tap"}, {28'b0, tap_cnt}, 32'd0);
    chk({tag, "_pix"}, {16'b0, pix_cnt}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = 32'h0; out_ready = 1'b1;
    step(); step();
    RST = 1'b0;
    chk_reset("rst");
    chk("add_op", {31'b0, add_op}, 32'd0);

    // back-to-back 9 x 1.0, ready high
    for (int i = 0; i < 9; i++) begin
      if (i == 4) chk("t1_tap4", {28'b0, tap_cnt}, 32'd4);
      put(F1);
    end
    chk("t1_ov", {31'b0, out_valid}, 32'd1);
    chk("t1_ir", {31'b0, in_ready}, 32'd0);
    chk("t1_tap0", {28'b0, tap_cnt}, 32'd0);
    take("t1", F9);
    chk("t1_ov_low", {31'b0, out_valid}, 32'd0);

    // backpressure for 5 cycles, offered beat must not be taken
    out_ready = 1'b0;
    put9(F1);
    in_valid = 1'b1; in_data = F3;
    for (int i = 0; i < 5; i++) begin
      chk("t2_ov", {31'b0, out_valid}, 32'd1);
      chk("t2_od", out_data, F9);
      chk("t2_ir", {31'b0, in_ready}, 32'd0);
      step();
    end
    in_valid = 1'b0;
    chk("t2_tap", {28'b0, tap_cnt}, 32'd0);
    take("t2", F9);

    // mixed values with random gaps
    for (int i = 0; i < 9; i++) begin
      put(i == 0 ? F3 : (i == 1 ? FM1 : F1));
      if (i < 8) begin
        chk("t3_tap", {28'b0, tap_cnt}, 32'(i + 1));
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          step();
          chk("t3_hold", {28'b0, tap_cnt}, 32'(i + 1));
        end
      end
    end
    take("t3", F9);

    // flush mid-pixel, concurrent beat dropped
    for (int i = 0; i < 4; i++) put(F1);
    flush = 1'b1; in_valid = 1'b1; in_data = F1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_tap", {28'b0, tap_cnt}, 32'd0);
    chk("t4_pix", {16'b0, pix_cnt}, 32'(exp_pix));
    put9(F2);
    take("t4", F18);

    // reset mid-pixel
    for (int i = 0; i < 5; i++) put(F1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk_reset("t5");
    exp_pix = 0;
    put9(F1);
    take("t5", F9);

    // zero operands
    put(F0);
    in_valid = 1'b1; in_data = F0;
    #1;
`ifndef CONV_ACCUM_ZERO_SKIP_EN
    chk("t6_opb", add_op_b, 32'h0);
    chk("t6_opa", add_op_a, 32'h0);
`endif
    step();
    in_valid = 1'b0;
    chk("t6_tap", {28'b0, tap_cnt}, 32'd2);
    put(F1);
    for (int i = 0; i < 6; i++) put(F0);
    take("t6", F1);
    put9(F0);
    take("t6z", F0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
